// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory store responder: MMIO map and the
// store-log entry layout.
package dmem_pkg;

  localparam logic [31:0] MMIO_BASE   = 32'hFFFFFF00;
  localparam logic [7:0]  TOHOST_OFS  = 8'h00;
  localparam logic [7:0]  CONSOLE_OFS = 8'h04;
  localparam logic [7:0]  CYCLES_OFS  = 8'h08;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } log_entry_t;

  // The MMIO page is the top 256 bytes of the address space.
  function automatic logic is_mmio(input logic [31:0] adr);
    return adr[31:8] == MMIO_BASE[31:8];
  endfunction

endpackage

// File: rtl/dmem_store_responder_fifo.sv
// Synchronous store-log FIFO; drops pushes when full unless a pop frees a slot
// in the same cycle, and remembers the drop in a sticky overflow flag.
module store_log_fifo
  import dmem_pkg::*;
#(
  parameter int LOG_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  log_entry_t push_entry,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output log_entry_t head,
  output logic       overflow
);

  localparam int PW = $clog2(LOG_DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(LOG_DEPTH);

  log_entry_t     store [LOG_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    count;
  logic           do_pop;
  logic           do_push;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : store[rd_ptr];

  // Pointers wrap naturally because LOG_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
      if (push && !do_push) begin
        overflow <= 1'b1;
      end
    end
  end

  // Entry storage is not cleared by reset; head is masked while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (do_push) begin
      store[wr_ptr] <= push_entry;
    end
  end

endmodule

// File: rtl/dmem_store_responder.sv
// Data-memory responder for the CPU store/load port: word RAM, MMIO page
// (TOHOST, CONSOLE, CYCLES) and a drainable log of every store.
module dmem_store_responder
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int LOG_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic        log_overflow,
  output logic        done,
  output logic [31:0] result
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0]   mem [MEM_WORDS];
  logic [AW-1:0] ram_idx;
  logic [7:0]    mmio_ofs;
  logic          mmio_hit;
  logic          ram_wr;
  logic          tohost_wr;
  logic [31:0]   cycles;
  logic          done_q;
  logic [31:0]   result_q;
  logic          log_empty;
  logic          log_full;
  log_entry_t    log_head;
  log_entry_t    new_entry;

  assign mmio_hit  = is_mmio(DataAdr);
  assign mmio_ofs  = DataAdr[7:0];
  assign ram_idx   = DataAdr[AW+1:2];
  assign ram_wr    = MemWrite && !mmio_hit;
  assign tohost_wr = MemWrite && mmio_hit && (mmio_ofs == TOHOST_OFS);

  // RAM keeps its contents across reset; only a store outside reset lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
    end else if (ram_wr) begin
      mem[ram_idx] <= WriteData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycles   <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      if (tohost_wr) begin
        done_q   <= 1'b1;
        result_q <= WriteData;
      end
    end
  end

  // Loads are combinational and deliberately see the pre-store RAM value.
  always_comb begin
    ReadData = '0;
    if (mmio_hit) begin
      case (mmio_ofs)
        TOHOST_OFS:  ReadData = result_q;
        CONSOLE_OFS: ReadData = '0;
        CYCLES_OFS:  ReadData = cycles;
        default:     ReadData = '0;
      endcase
    end else begin
      ReadData = mem[ram_idx];
    end
  end

  assign new_entry.addr = DataAdr;
  assign new_entry.data = WriteData;

  store_log_fifo #(
    .LOG_DEPTH (LOG_DEPTH)
  ) u_log (
    .clk        (clk),
    .rst_n      (reset),
    .push       (MemWrite),
    .push_entry (new_entry),
    .pop        (log_valid && log_ready),
    .full       (log_full),
    .empty      (log_empty),
    .head       (log_head),
    .overflow   (log_overflow)
  );

  assign log_valid = !log_empty;
  assign log_addr  = log_head.addr;
  assign log_data  = log_head.data;
  assign done      = done_q;
  assign result    = result_q;

endmodule

// File: tb/tb_dmem_store_responder.sv
// Self-checking bench for dmem_store_responder: directed vector table,
// multi-cycle corner sequences and randomized traffic against a queue model.
module tb_dmem_store_responder;

  localparam int MEM_WORDS = 256;
  localparam int LOG_DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        log_valid;
  logic        log_ready = 1'b0;
  logic [31:0] log_addr;
  logic [31:0] log_data;
  logic        log_overflow;
  logic        done;
  logic [31:0] result;

  dmem_store_responder #(
    .MEM_WORDS (MEM_WORDS),
    .LOG_DEPTH (LOG_DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .MemWrite     (MemWrite),
    .DataAdr      (DataAdr),
    .WriteData    (WriteData),
    .ReadData     (ReadData),
    .log_valid    (log_valid),
    .log_ready    (log_ready),
    .log_addr     (log_addr),
    .log_data     (log_data),
    .log_overflow (log_overflow),
    .done         (done),
    .result       (result)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of {addr,data}, sparse RAM by word index.
  logic [63:0] m_log [$];
  logic [31:0] m_ram [int];
  logic        m_overflow = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_result = '0;
  logic [31:0] m_cycles = '0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rdy;
    logic [31:0] exp_read;
    logic        exp_valid;
    logic [31:0] exp_laddr;
    logic [31:0] exp_ldata;
    logic        exp_done;
    logic [31:0] exp_result;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ram_index(input logic [31:0] a);
    return int'((a / 4) % MEM_WORDS);
  endfunction

  function automatic logic addr_is_mmio(input logic [31:0] a);
    return a >= 32'hFFFFFF00;
  endfunction

  task automatic model_reset();
    m_log.delete();
    m_overflow = 1'b0;
    m_done     = 1'b0;
    m_result   = '0;
    m_cycles   = '0;
  endtask

  task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] d,
                            input logic rdy);
    if (m_log.size() > 0 && rdy) void'(m_log.pop_front());
    if (we) begin
      if (m_log.size() < LOG_DEPTH) m_log.push_back({a, d});
      else m_overflow = 1'b1;
      if (!addr_is_mmio(a)) m_ram[ram_index(a)] = d;
      else if (a - 32'hFFFFFF00 == 0) begin
        m_done   = 1'b1;
        m_result = d;
      end
    end
    m_cycles = m_cycles + 1;
  endtask

  task automatic check_read(input string tag);
    logic [31:0] exp;
    if (addr_is_mmio(DataAdr)) begin
      case (DataAdr - 32'hFFFFFF00)
        0:       exp = m_result;
        8:       exp = m_cycles;
        default: exp = 0;
      endcase
      chk({tag, "_mmio_read"}, ReadData, exp);
    end else if (m_ram.exists(ram_index(DataAdr))) begin
      chk({tag, "_ram_read"}, ReadData, m_ram[ram_index(DataAdr)]);
    end
  endtask

  task automatic checkOutput();
    logic [63:0] h;
    h = (m_log.size() > 0) ? m_log[0] : 64'd0;
    chk("log_valid", 32'(log_valid), 32'(m_log.size() > 0));
    chk("log_addr", log_addr, h[63:32]);
    chk("log_data", log_data, h[31:0]);
    chk("log_overflow", 32'(log_overflow), 32'(m_overflow));
    chk("done", 32'(done), 32'(m_done));
    chk("result", result, m_result);
    check_read("post");
  endtask

  // Called at posedge+1; ends at the next posedge+1 with outputs checked.
  task automatic applyStimulus(input logic we, input logic [31:0] a, input logic [31:0] d,
                               input logic rdy);
    MemWrite  = we;
    DataAdr   = a;
    WriteData = d;
    log_ready = rdy;
    #2;
    check_read("pre");
    @(posedge clk);
    model_edge(we, a, d, rdy);
    #1;
    checkOutput();
  endtask

  task automatic add_vec(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic rdy, input logic [31:0] er, input logic ev,
                         input logic [31:0] ela, input logic [31:0] eld,
                         input logic ed, input logic [31:0] eres);
    vec_t v;
    v.we = we; v.addr = a; v.data = d; v.rdy = rdy; v.exp_read = er; v.exp_valid = ev;
    v.exp_laddr = ela; v.exp_ldata = eld; v.exp_done = ed; v.exp_result = eres;
    vecs.push_back(v);
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int n;
    logic [31:0] last_a, last_d;

    add_vec(1, 32'h0,        32'h5,    0, 32'h5,  1, 32'h0,        32'h5,    0, 32'h0);
    add_vec(1, 32'h4,        32'hA,    0, 32'hA,  1, 32'h0,        32'h5,    0, 32'h0);
    add_vec(0, 32'h0,        32'h0,    0, 32'h5,  1, 32'h0,        32'h5,    0, 32'h0);
    add_vec(0, 32'h4,        32'h0,    1, 32'hA,  1, 32'h4,        32'hA,    0, 32'h0);
    add_vec(0, 32'h0,        32'h0,    1, 32'h5,  0, 32'h0,        32'h0,    0, 32'h0);
    add_vec(1, 32'hFFFFFF00, 32'h0,    0, 32'h0,  1, 32'hFFFFFF00, 32'h0,    1, 32'h0);
    add_vec(1, 32'hFFFFFF00, 32'h1,    1, 32'h1,  1, 32'hFFFFFF00, 32'h1,    1, 32'h1);
    add_vec(0, 32'hFFFFFF10, 32'h0,    1, 32'h0,  0, 32'h0,        32'h0,    1, 32'h1);
    add_vec(1, 32'h400,      32'h77,   0, 32'h77, 1, 32'h400,      32'h77,   1, 32'h1);
    add_vec(0, 32'h0,        32'h0,    1, 32'h77, 0, 32'h0,        32'h0,    1, 32'h1);
    add_vec(1, 32'hFFFFFF04, 32'h41,   0, 32'h0,  1, 32'hFFFFFF04, 32'h41,   1, 32'h1);
    add_vec(1, 32'hFFFFFF0C, 32'hDEAD, 1, 32'h0,  1, 32'hFFFFFF0C, 32'hDEAD, 1, 32'h1);
    add_vec(0, 32'h4,        32'h0,    1, 32'hA,  0, 32'h0,        32'h0,    1, 32'h1);

    // Reset state while reset is held low.
    #3;
    chk("rst_log_valid", 32'(log_valid), 32'd0);
    chk("rst_log_addr", log_addr, 32'd0);
    chk("rst_log_data", log_data, 32'd0);
    chk("rst_overflow", 32'(log_overflow), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    DataAdr = 32'hFFFFFF08;
    #1;
    chk("rst_cycles", ReadData, 32'd0);
    release_reset();

    // Cycle counter after 20 edges.
    for (int i = 0; i < 20; i++) applyStimulus(0, 32'hFFFFFF08, 0, 0);
    chk("cycles_20", ReadData, 32'd20);

    $display("[TB] directed vector table");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].rdy);
      chk($sformatf("tbl%0d_read", i), ReadData, vecs[i].exp_read);
      chk($sformatf("tbl%0d_valid", i), 32'(log_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("tbl%0d_laddr", i), log_addr, vecs[i].exp_laddr);
      chk($sformatf("tbl%0d_ldata", i), log_data, vecs[i].exp_ldata);
      chk($sformatf("tbl%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
      chk($sformatf("tbl%0d_result", i), result, vecs[i].exp_result);
    end

    $display("[TB] overflow with log_ready low");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, 32'h100 + 32'(i) * 4, 32'h1000 + 32'(i), 0);
      if (i == 7) chk("ovf_after8", 32'(log_overflow), 32'd0);
    end
    chk("ovf_after9", 32'(log_overflow), 32'd1);
    n = 0;
    while (log_valid && n < 16) begin
      chk("ovf_drain_addr", log_addr, 32'h100 + 32'(n) * 4);
      chk("ovf_drain_data", log_data, 32'h1000 + 32'(n));
      applyStimulus(0, 32'h100, 0, 1);
      n++;
    end
    chk("ovf_drain_count", 32'(n), 32'd8);
    chk("ovf_sticky", 32'(log_overflow), 32'd1);

    $display("[TB] asynchronous reset mid-drain");
    applyStimulus(1, 32'h20, 32'h1234, 0);
    applyStimulus(1, 32'hFFFFFF00, 32'h99, 0);
    applyStimulus(1, 32'h24, 32'h5678, 0);
    applyStimulus(0, 32'hFFFFFF08, 0, 1);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async_done", 32'(done), 32'd0);
    chk("async_valid", 32'(log_valid), 32'd0);
    chk("async_cycles", ReadData, 32'd0);
    checkOutput();
    MemWrite  = 1'b1;
    DataAdr   = 32'h20;
    WriteData = 32'hBAD;
    log_ready = 1'b0;
    release_reset();
    MemWrite = 1'b0;
    #1;
    chk("rst_store_ram", ReadData, 32'h1234);
    chk("rst_store_log", 32'(log_valid), 32'd0);
    applyStimulus(0, 32'h20, 0, 0);

    $display("[TB] full log with simultaneous push and pop");
    for (int i = 0; i < LOG_DEPTH; i++) applyStimulus(1, 32'h200 + 32'(i) * 4, 32'h2000 + 32'(i), 0);
    applyStimulus(1, 32'h300, 32'h3000, 1);
    chk("fullpp_overflow", 32'(log_overflow), 32'd0);
    chk("fullpp_head", log_addr, 32'h204);
    n = 0;
    last_a = '0;
    last_d = '0;
    while (log_valid && n < 16) begin
      last_a = log_addr;
      last_d = log_data;
      applyStimulus(0, 32'h0, 0, 1);
      n++;
    end
    chk("fullpp_count", 32'(n), 32'd8);
    chk("fullpp_last_addr", last_a, 32'h300);
    chk("fullpp_last_data", last_d, 32'h3000);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 5))
        0:       a = 32'hFFFFFF00 + 32'($urandom_range(0, 5)) * 4;
        1:       a = $urandom;
        default: a = 32'($urandom_range(0, 2047)) * 4 + 32'($urandom_range(0, 3));
      endcase
      applyStimulus(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 2) != 0));
    end

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_store_responder.md
Name: dmem_store_responder

Overview:
- Data-memory responder on the riscv_top store/load port (DataAdr, WriteData, MemWrite); the counterpart to the CPU's store initiator.
- Provides word RAM with combinational read and synchronous write, plus a small MMIO page.
- Captures every store into a drainable log FIFO so benches can check store order without probing internal hierarchy.

Parameters:
- MEM_WORDS, 256, RAM depth in 32-bit words; power of two.
- LOG_DEPTH, 8, store-log FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- MemWrite  in  1  store strobe from CPU, sampled on rising clk
- DataAdr  in  32  byte address from CPU
- WriteData  in  32  store data from CPU
- ReadData  out  32  load data, combinational from DataAdr
- log_valid  out  1  log FIFO head entry valid
- log_ready  in  1  consumer pops the head when log_valid && log_ready at clk edge
- log_addr  out  32  head entry address
- log_data  out  32  head entry data
- log_overflow  out  1  sticky: a store was dropped because the log was full
- done  out  1  sticky: TOHOST has been written
- result  out  32  last value written to TOHOST

Behaviour:
- Address decode:
  - MMIO when DataAdr[31:8] == 24'hFFFFFF; otherwise RAM.
  - RAM index = DataAdr[log2(MEM_WORDS)+1:2]; upper bits and DataAdr[1:0] are ignored, so addresses wrap modulo the RAM size.
- MMIO map (offset DataAdr[7:0]):
  - 0x00 TOHOST: write sets done=1 and result=WriteData; read returns result.
  - 0x04 CONSOLE: write is logged only; read returns 0.
  - 0x08 CYCLES: read-only free-running 32-bit counter; writes are logged but have no other effect.
  - Any other offset reads 0; writes to it are logged only.
- RAM:
  - Write when MemWrite=1 and RAM decoded; the new value is visible to ReadData from the cycle after the edge.
  - Read is combinational, with no bypass of a same-cycle write.
  - RAM contents are not affected by reset; they are undefined until written (simulation initialises to 0).
- CYCLES:
  - 0 during reset.
  - Increments by 1 every clk edge after reset deasserts; wraps from 0xFFFFFFFF to 0.
- Store log:
  - Every edge with MemWrite=1 (RAM or MMIO) pushes {DataAdr, WriteData}.
  - Pop occurs when log_valid && log_ready.
  - log_valid = count != 0; log_addr/log_data always show the head entry (0 when empty).
  - Full, push without pop: entry dropped, log_overflow <= 1, FIFO unchanged.
  - Full, push with pop: both happen, count stays at LOG_DEPTH, no overflow.
  - Empty, push with log_ready=1: push only; the entry appears next cycle.
  - Pointers wrap modulo LOG_DEPTH; count width is log2(LOG_DEPTH)+1.
- Reset (asynchronous, active-low, at any time, including mid-drain or same cycle as a store):
  - done=0, result=0, log_overflow=0, log_valid=0, log_addr=0, log_data=0, FIFO pointers/count=0, CYCLES=0.
  - A store coincident with reset is discarded.
  - ReadData follows RAM contents unchanged.
- Latency: loads 0 cycles (combinational); store-to-log visibility 1 cycle; TOHOST-to-done 1 cycle.
- done is never cleared except by reset; a second TOHOST write updates result and keeps done=1.

Decomposition:
- Package dmem_pkg holds:
  - MMIO_BASE = 32'hFFFFFF00;
  - offsets TOHOST_OFS=8'h00, CONSOLE_OFS=8'h04, CYCLES_OFS=8'h08;
  - typedef log_entry_t as a packed struct {addr[31:0], data[31:0]}.
- Sub-module store_log_fifo (synchronous FIFO):
  - parameterised by LOG_DEPTH, carrying log_entry_t;
  - exposes push, pop, full, empty, head, overflow.
- The top level contains decode, RAM, MMIO registers and the cycle counter.

Test Plan:
- Reset, then store 0x5 to 0x0 and 0xA to 0x4; read both addresses -> ReadData 5 then 10; log yields (0x0,5),(0x4,10) in order.
- With log_ready=0, issue 9 stores (LOG_DEPTH=8) -> log_overflow=1 after the 9th; draining yields exactly the first 8 entries.
- Fill log to 8, then one cycle with MemWrite=1 and log_ready=1 -> count stays 8, log_overflow=0, new entry last in drain order.
- Store 0x00000000 to 0xFFFFFF00 -> done=1 and result=0 next cycle; store 0x1 there -> result=1, done still 1.
- Release reset, wait 20 edges, read 0xFFFFFF08 -> ReadData=20; assert reset mid-run -> CYCLES, done, log state return to 0 asynchronously.
- Store 0x77 to 0x400 with MEM_WORDS=256 -> reading 0x0 returns 0x77 (wrap); reading 0xFFFFFF10 returns 0.
